// File: rtl/pe_input_sequencer_if.sv
// pe_seq_if: host-load, control and PE-side signals of one input sequencer.
interface pe_seq_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int LEN_WIDTH    = 5
);
  logic                    host_wr_en;
  logic                    host_wr_sel;
  logic [ADDR_WIDTH-1:0]   host_wr_addr;
  logic [7:0]              host_wr_data;
  logic                    start;
  logic [LEN_WIDTH-1:0]    vec_len;
  logic                    abort;
  logic                    busy;
  logic                    done;
  logic                    len_err;
  logic                    pe_enable;
  logic                    pe_load_weight;
  logic [WEIGHT_WIDTH-1:0] pe_weight_out;
  logic                    pe_clear_acc;
  logic [DATA_WIDTH-1:0]   pe_activation_out;
  logic                    pe_upstream_valid;
  logic                    pe_upstream_ready;
  logic                    pe_forward_output;
  modport master (
    output host_wr_en, host_wr_sel, host_wr_addr, host_wr_data, start, vec_len, abort,
           pe_upstream_ready,
    input  busy, done, len_err, pe_enable, pe_load_weight, pe_weight_out, pe_clear_acc,
           pe_activation_out, pe_upstream_valid, pe_forward_output
  );
  modport slave (
    input  host_wr_en, host_wr_sel, host_wr_addr, host_wr_data, start, vec_len, abort,
           pe_upstream_ready,
    output busy, done, len_err, pe_enable, pe_load_weight, pe_weight_out, pe_clear_acc,
           pe_activation_out, pe_upstream_valid, pe_forward_output
  );
endinterface

// File: rtl/pe_input_sequencer.sv
// pe_input_sequencer: buffers weights/activations and plays them into one PE as load, clear, stream, forward.
module pe_input_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int LEN_WIDTH    = 5
) (
  input logic   clk,
  input logic   rst_n,
  pe_seq_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_CLEAR, S_STREAM, S_FORWARD, S_DONE} state_t;
  state_t                  r_state, w_state;
  logic [ADDR_WIDTH-1:0]   r_idx, w_idx;
  logic [LEN_WIDTH-1:0]    r_len, w_len;
  logic                    r_len_err, w_len_err;
  logic                    w_last;
  logic [WEIGHT_WIDTH-1:0] r_wbuf [DEPTH];
  logic [DATA_WIDTH-1:0]   r_abuf [DEPTH];
  // Buffers carry no reset; host writes land only while idle so a run sees frozen data.
  always_ff @(posedge clk) begin
    if (bus.host_wr_en && r_state == S_IDLE) begin
      if (bus.host_wr_sel) r_wbuf[bus.host_wr_addr] <= bus.host_wr_data[WEIGHT_WIDTH-1:0];
      else r_abuf[bus.host_wr_addr] <= bus.host_wr_data[DATA_WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_len     <= w_len;
      r_len_err <= w_len_err;
    end
  end
  assign w_last = LEN_WIDTH'(r_idx) == r_len - LEN_WIDTH'(1);
  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_len     = r_len;
    w_len_err = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start && !bus.abort) begin
        if (bus.vec_len != '0 && bus.vec_len <= LEN_WIDTH'(DEPTH)) begin
          w_state = S_LOAD_W;
          w_len   = bus.vec_len;
          w_idx   = '0;
        end else w_len_err = 1'b1;
      end
      S_LOAD_W: begin
        w_idx   = w_last ? '0 : r_idx + 1'b1;
        w_state = w_last ? S_CLEAR : S_LOAD_W;
      end
      S_CLEAR:   w_state = S_STREAM;
      S_STREAM: if (bus.pe_upstream_ready) begin
        w_idx   = w_last ? '0 : r_idx + 1'b1;
        w_state = w_last ? S_FORWARD : S_STREAM;
      end
      S_FORWARD: w_state = S_DONE;
      default:   w_state = S_IDLE;
    endcase
    if (bus.abort && r_state != S_IDLE) begin
      w_state = S_IDLE;
      w_idx   = '0;
    end
  end
  assign bus.busy              = r_state != S_IDLE;
  assign bus.done              = r_state == S_DONE;
  assign bus.len_err           = r_len_err;
  assign bus.pe_enable         = r_state inside {S_LOAD_W, S_CLEAR, S_STREAM, S_FORWARD};
  assign bus.pe_load_weight    = r_state == S_LOAD_W;
  assign bus.pe_weight_out     = r_state == S_LOAD_W ? r_wbuf[r_idx] : '0;
  assign bus.pe_clear_acc      = r_state == S_CLEAR;
  assign bus.pe_upstream_valid = r_state == S_STREAM;
  assign bus.pe_activation_out = r_state == S_STREAM ? r_abuf[r_idx] : '0;
  assign bus.pe_forward_output = r_state == S_FORWARD;
endmodule

// File: doc/pe_input_sequencer.md
Name: pe_input_sequencer

Overview: Upstream feeder for neural_network_pe. It holds a host-loaded weight vector and activation vector in local register buffers. On start it drives the PE's load_weight, clear_acc, activation valid/ready and forward_output controls in a fixed sequence: load weights, clear, stream activations, forward. One instance feeds one PE.

Parameters:
DATA_WIDTH, 8, activation width (signed)
WEIGHT_WIDTH, 8, weight width (signed)
DEPTH, 16, entries per buffer
ADDR_WIDTH, 4, log2(DEPTH)
LEN_WIDTH, 5, vec_len width (ADDR_WIDTH+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
host_wr_en  in  1  buffer write strobe
host_wr_sel  in  1  0=activation buffer, 1=weight buffer
host_wr_addr  in  ADDR_WIDTH  write index
host_wr_data  in  8  write data (low DATA_WIDTH/WEIGHT_WIDTH bits used)
start  in  1  begin sequence (sampled in IDLE only)
vec_len  in  LEN_WIDTH  entries to process, valid 1..DEPTH
abort  in  1  synchronous abort
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
len_err  out  1  one-cycle pulse: start rejected for bad vec_len
pe_enable  out  1  to PE enable
pe_load_weight  out  1  to PE load_weight
pe_weight_out  out  WEIGHT_WIDTH  to PE weight_in
pe_clear_acc  out  1  to PE clear_acc
pe_activation_out  out  DATA_WIDTH  to PE activation_in
pe_upstream_valid  out  1  to PE upstream_valid
pe_upstream_ready  in  1  from PE upstream_ready
pe_forward_output  out  1  to PE forward_output

Behaviour:
- Reset: synchronous, active-low; on the rst_n=0 edge the state goes to IDLE, idx=0, len_q=0, and all outputs go to 0. Buffer contents are not reset. Reset mid-sequence behaves the same: IDLE on the next edge, outputs 0.
- Outputs are a function of registered state, idx and buffers only. There is no combinational path from any input to any output.
- States: IDLE, LOAD_W, CLEAR, STREAM, FORWARD, DONE.
- IDLE: all outputs 0.
  - start=1 with 1<=vec_len<=DEPTH: latch len_q=vec_len, idx=0, go to LOAD_W.
  - start=1 with vec_len=0 or vec_len>DEPTH: stay in IDLE, pulse len_err for one cycle.
- LOAD_W: pe_load_weight=1, pe_weight_out=wbuf[idx], pe_enable=1. idx increments every cycle. After idx=len_q-1, go to CLEAR with idx=0. This state takes exactly len_q cycles; ready is not used.
- CLEAR: pe_clear_acc=1 and pe_enable=1 for exactly one cycle, then go to STREAM.
- STREAM: pe_upstream_valid=1, pe_activation_out=abuf[idx], pe_enable=1.
  - Valid and data stay stable until pe_upstream_ready=1 at an edge (transfer).
  - On a transfer, idx increments. A transfer with idx=len_q-1 moves to FORWARD.
  - Ready low stalls indefinitely with no timeout.
- FORWARD: pe_forward_output=1 and pe_enable=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, pe_enable=0, then go to IDLE.
- busy=1 in every state except IDLE.
- Latency with ready held high and start accepted at edge E0 (N = len_q):
  - LOAD_W occupies cycles 1..N.
  - CLEAR occupies cycle N+1.
  - STREAM occupies cycles N+2..2N+1.
  - FORWARD occupies cycle 2N+2.
  - DONE occupies cycle 2N+3.
  - IDLE from cycle 2N+4.
- start while busy: ignored. start and abort together in IDLE: abort wins, start is ignored.
- abort=1 in any non-IDLE state: go to IDLE on the next edge with outputs 0 and no done pulse. An abort in STREAM drops valid without a transfer.
- Host writes:
  - Accepted only in IDLE; writes while busy are silently dropped.
  - Write data is visible to a start on the following cycle.
  - A write and a start on the same edge: the write is accepted and the sequence uses the new value.
- len_q and buffer values are frozen for the whole sequence.

Test Plan:
- Basic: weights [4,4,4], activations [1,2,3], vec_len=3, ready=1 → pe_load_weight high for cycles 1-3 with weight 4; clear_acc at cycle 4; valid at cycles 5-7 carrying 1,2,3; forward at 8; done at 9; busy high for cycles 1-9.
- Backpressure: vec_len=2, activations [5,-2], ready low for 3 cycles at the first STREAM cycle → activation 5 and valid held stable for 4 cycles; exactly 2 transfers; done 3 cycles later than unstalled.
- Bounds: vec_len=0 and vec_len=17 → len_err pulse, busy stays 0, no PE strobes. vec_len=16 with all entries 7 → 16 load cycles and 16 transfers.
- Abort: abort in STREAM after 1 transfer → IDLE next cycle, valid and pe_enable 0, no done. A new start then replays from LOAD_W.
- Reset mid-LOAD_W: rst_n=0 for one edge → all outputs 0, busy 0. Buffer contents are retained: the next sequence uses the prior weights.
- Host write during busy to weight addr 0 (value 9) → ignored; the next run still outputs the old weight.
